// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode encoding and the combinational ALU compute function
package alu_pkg;

  localparam int OPW   = 4;
  localparam int RESW  = 8;
  localparam int ADDRW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_CAT = 4'd9
  } opcode_e;

  // One retired operation's worth of result and status.
  typedef struct packed {
    logic [RESW-1:0] data;
    logic            gt;
    logic            st;
    logic            eq;
    logic            v;
  } alu_out_t;

  // Pure combinational ALU: result plus flags for one operand pair.
  // Comparison flags are opcode-independent so reserved opcodes still report them.
  function automatic alu_out_t alu_compute(
    input logic [OPW-1:0] a,
    input logic [OPW-1:0] b,
    input logic [OPW-1:0] op
  );
    alu_out_t            r;
    logic [RESW-1:0]     a8;
    logic [RESW-1:0]     b8;
    logic [RESW-1:0]     sum;
    logic [2*RESW-1:0]   shl_full;
    logic [OPW-1:0]      shr_lost;

    a8       = {{(RESW-OPW){1'b0}}, a};
    b8       = {{(RESW-OPW){1'b0}}, b};
    sum      = a8 + b8;
    // Shift inside a double-width word so the bits pushed past bit 7 stay visible for v.
    shl_full = {{(2*RESW-OPW){1'b0}}, a} << b[2:0];
    // Bits of A that fall off the bottom on a right shift by b (b < 4).
    shr_lost = a & ~(4'hF << b);

    r      = '0;
    r.gt   = (a > b);
    r.st   = (a < b);
    r.eq   = (a == b);

    case (opcode_e'(op))
      OP_ADD: begin
        r.data = sum;
        r.v    = (sum > 8'd15);
      end
      OP_SUB: begin
        r.data = a8 - b8;
        r.v    = (a < b);
      end
      OP_MUL: begin
        // 15*15 = 225 fits in 8 bits, so no truncation is possible here.
        r.data = a8 * b8;
        r.v    = (r.data > 8'd15);
      end
      OP_AND: r.data = {{(RESW-OPW){1'b0}}, a & b};
      OP_OR:  r.data = {{(RESW-OPW){1'b0}}, a | b};
      OP_XOR: r.data = {{(RESW-OPW){1'b0}}, a ^ b};
      OP_NOT: r.data = {{(RESW-OPW){1'b0}}, ~a};
      OP_SHL: begin
        r.data = shl_full[RESW-1:0];
        r.v    = |shl_full[2*RESW-1:RESW];
      end
      OP_SHR: begin
        if (b >= 4'd4) begin
          // Every bit of A is shifted out.
          r.data = '0;
          r.v    = |a;
        end else begin
          r.data = a8 >> b;
          r.v    = |shr_lost;
        end
      end
      OP_CAT: r.data = {a, b};
      default: begin
        r.data = '0;
        r.v    = 1'b0;
      end
    endcase

    return r;
  endfunction

endpackage

// File: rtl/alu_waddr_counter.sv
// rtl/alu_waddr_counter.sv - 3-bit wrapping write-slot counter
module alu_waddr_counter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [ADDRW-1:0] addr
);

  // Advance one slot per retired operation; natural wrap from 7 back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (inc) begin
      addr <= addr + ADDRW'(1);
    end
  end

endmodule

// File: rtl/alu_wb_addr_gen.sv
// rtl/alu_wb_addr_gen.sv - registered 4-bit ALU with paired register-file write address
module alu_wb_addr_gen
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  input  logic [OPW-1:0]   opcode,
  output logic [RESW-1:0]  result_data,
  output logic             gt,
  output logic             st,
  output logic             eq,
  output logic             v,
  output logic [ADDRW-1:0] write_addr
);

  alu_out_t         alu_next;
  logic [ADDRW-1:0] slot;

  // Next-slot counter; reset inside the counter dominates the increment.
  alu_waddr_counter u_waddr_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (en),
    .addr  (slot)
  );

  // Result and flags for the operands currently presented.
  always_comb begin
    alu_next = alu_compute(a, b, opcode);
  end

  // Single output stage: load on an enabled edge, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_data <= '0;
      gt          <= 1'b0;
      st          <= 1'b0;
      eq          <= 1'b0;
      v           <= 1'b0;
      write_addr  <= '0;
    end else if (en) begin
      result_data <= alu_next.data;
      gt          <= alu_next.gt;
      st          <= alu_next.st;
      eq          <= alu_next.eq;
      v           <= alu_next.v;
      write_addr  <= slot;
    end
  end

endmodule

// File: tb/tb_alu_wb_addr_gen.sv
// tb/tb_alu_wb_addr_gen.sv - self-checking bench for alu_wb_addr_gen against an arithmetic reference model
module tb_alu_wb_addr_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] opcode;
  logic [7:0] result_data;
  logic       gt;
  logic       st;
  logic       eq;
  logic       v;
  logic [2:0] write_addr;

  int tests_run;
  int tests_failed;

  // Reference model state: what the outputs should currently show.
  int exp_data;
  int exp_gt;
  int exp_st;
  int exp_eq;
  int exp_v;
  int exp_addr;
  int ops_retired;

  alu_wb_addr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .a           (a),
    .b           (b),
    .opcode      (opcode),
    .result_data (result_data),
    .gt          (gt),
    .st          (st),
    .eq          (eq),
    .v           (v),
    .write_addr  (write_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference ALU using plain integer arithmetic on the operation definitions.
  task automatic ref_alu(input int ia, input int ib, input int op, output int r, output int ov);
    int p;
    r  = 0;
    ov = 0;
    case (op)
      0: begin r = ia + ib; ov = (r > 15); end
      1: begin r = (ia - ib + 256) % 256; ov = (ia < ib); end
      2: begin r = ia * ib; ov = (r > 15); end
      3: r = ia & ib;
      4: r = ia | ib;
      5: r = ia ^ ib;
      6: r = 15 - ia;
      7: begin
        p  = ia * (1 << (ib % 8));
        r  = p % 256;
        ov = (p >= 256);
      end
      8: begin
        if (ib >= 4) begin
          r  = 0;
          ov = (ia != 0);
        end else begin
          r  = ia / (1 << ib);
          ov = ((ia % (1 << ib)) != 0);
        end
      end
      9: r = ia * 16 + ib;
      default: begin r = 0; ov = 0; end
    endcase
  endtask

  // Drive one cycle, advance the model, and compare all outputs just after the edge.
  task automatic step(input logic r, input logic e, input int ia, input int ib, input int iop, input string tag);
    int res;
    int ov;
    @(negedge clk);
    reset  = r;
    en     = e;
    a      = 4'(ia);
    b      = 4'(ib);
    opcode = 4'(iop);
    @(posedge clk);
    #1;
    if (r) begin
      exp_data = 0; exp_gt = 0; exp_st = 0; exp_eq = 0; exp_v = 0; exp_addr = 0;
      ops_retired = 0;
    end else if (e) begin
      ref_alu(ia, ib, iop, res, ov);
      exp_data    = res;
      exp_v       = ov;
      exp_gt      = (ia > ib);
      exp_st      = (ia < ib);
      exp_eq      = (ia == ib);
      exp_addr    = ops_retired % 8;
      ops_retired = ops_retired + 1;
    end
    check({tag, ".data"}, 32'(result_data), 32'(exp_data));
    check({tag, ".flags"}, 32'({gt, st, eq, v}), 32'({exp_gt[0], exp_st[0], exp_eq[0], exp_v[0]}));
    check({tag, ".addr"}, 32'(write_addr), 32'(exp_addr));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ops_retired  = 0;
    exp_data = 0; exp_gt = 0; exp_st = 0; exp_eq = 0; exp_v = 0; exp_addr = 0;
    reset  = 1'b1;
    en     = 1'b1;
    a      = 4'd5;
    b      = 4'd3;
    opcode = 4'd0;

    // Reset held two cycles with an operation pending: nothing retires.
    step(1'b1, 1'b1, 5, 3, 0, "rst0");
    step(1'b1, 1'b1, 5, 3, 0, "rst1");
    check("rst_all_zero", 32'({result_data, gt, st, eq, v, write_addr}), 32'h0);

    // Directed operations with literal expectations.
    step(1'b0, 1'b1, 9, 8, 0, "add_9_8");
    check("add_9_8_lit", 32'({result_data, gt, st, eq, v, write_addr}), 32'({8'h11, 4'b1001, 3'd0}));
    step(1'b0, 1'b1, 2, 2, 0, "add_2_2");
    check("add_2_2_lit", 32'({result_data, gt, st, eq, v, write_addr}), 32'({8'h04, 4'b0010, 3'd1}));
    step(1'b0, 1'b1, 3, 5, 1, "sub_3_5");
    check("sub_3_5_lit", 32'({result_data, st, v}), 32'({8'hFE, 1'b1, 1'b1}));
    step(1'b0, 1'b1, 15, 15, 2, "mul_15_15");
    check("mul_15_15_lit", 32'({result_data, eq, v}), 32'({8'hE1, 1'b1, 1'b1}));
    step(1'b0, 1'b1, 11, 3, 7, "shl_b_3");
    check("shl_b_3_lit", 32'({result_data, v}), 32'({8'h58, 1'b0}));
    step(1'b0, 1'b1, 11, 1, 8, "shr_b_1");
    check("shr_b_1_lit", 32'({result_data, v}), 32'({8'h05, 1'b1}));
    step(1'b0, 1'b1, 10, 5, 9, "cat_a_5");
    check("cat_a_5_lit", 32'({result_data, write_addr}), 32'({8'hA5, 3'd6}));

    // Hold: en low with random inputs leaves everything unchanged.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), "hold");
    end
    check("hold_lit", 32'({result_data, write_addr}), 32'({8'hA5, 3'd6}));

    // Reset together with en wins; then nine ops show the slot wrapping.
    step(1'b1, 1'b1, 7, 7, 0, "rst_en");
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), "wrap");
      check("wrap_addr_lit", 32'(write_addr), 32'(i % 8));
    end

    // Exhaustive operand/opcode sweep with random idle cycles mixed in.
    for (int op = 0; op < 16; op++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if ($urandom_range(0, 7) == 0) begin
            step(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), "sweep_idle");
          end
          step(1'b0, 1'b1, ia, ib, op, "sweep");
        end
      end
    end

    // Random traffic with occasional resets and idle cycles.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
